// File: rtl/tl_a_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tl_a_arbiter_pkg
// Shared TileLink definitions used by the A-channel arbiter.
//   - A-channel opcode constants
//   - arbiter FSM state encoding
//   - tl_has_data(): true for opcodes whose messages carry a data payload
// ---------------------------------------------------------------------------
package tl_a_arbiter_pkg;

    localparam logic [2:0] TL_OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_OP_ARITHMETIC  = 3'd2;
    localparam logic [2:0] TL_OP_LOGICAL     = 3'd3;
    localparam logic [2:0] TL_OP_GET         = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    // Data-carrying A messages occupy opcodes 0..3.
    function automatic logic tl_has_data(input logic [2:0] op);
        return (op <= TL_OP_LOGICAL);
    endfunction

endpackage

// File: rtl/tl_a_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// tl_rr_pick
// Round-robin priority picker: returns the first requesting client found
// when searching upward from i_ptr with wrap-around.
//   i_req  [N-1:0]      request vector
//   i_ptr  [IDX_W-1:0]  highest-priority index
//   o_gnt  [N-1:0]      one-hot grant, zero when no request is set
// ---------------------------------------------------------------------------
module tl_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    logic             w_found;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // The extra sum bit lets the modulo work for non-power-of-two N.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_a_arbiter.sv
// ---------------------------------------------------------------------------
// tl_a_arbiter
// Round-robin arbiter merging N_CLIENTS TileLink A channels onto one manager
// A port. A grant is locked while a valid is pending (HOLD) and for all
// beats of a multi-beat message (BURST), so beats never interleave.
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i/ready_o  per-client A handshake
//   req_opcode_i         per-client opcode, client i at [i*3 +: 3]
//   req_size_i           per-client log2 size, client i at [i*4 +: 4]
//   out_valid_o/ready_i  downstream A handshake
//   gnt_oh_o, gnt_idx_o  one-hot and binary grant for the external data mux
//   busy_o               grant locked (HOLD or BURST)
// ---------------------------------------------------------------------------
module tl_a_arbiter
    import tl_a_arbiter_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int DATA_W    = 64,
    parameter int CNT_W     = 13
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CLIENTS-1:0]         req_valid_i,
    output logic [N_CLIENTS-1:0]         req_ready_o,
    input  logic [N_CLIENTS*3-1:0]       req_opcode_i,
    input  logic [N_CLIENTS*4-1:0]       req_size_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [N_CLIENTS-1:0]         gnt_oh_o,
    output logic [$clog2(N_CLIENTS)-1:0] gnt_idx_o,
    output logic                         busy_o
);

    localparam int IDX_W   = $clog2(N_CLIENTS);
    localparam int BEAT_LG = $clog2(DATA_W / 8);

    logic [1:0]           r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [N_CLIENTS-1:0] r_gnt;
    logic [CNT_W-1:0]     r_remaining;

    logic [N_CLIENTS-1:0] w_pick;
    logic [N_CLIENTS-1:0] w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [IDX_W-1:0]     w_next_ptr;
    logic [2:0]           w_op;
    logic [3:0]           w_size;
    logic [3:0]           w_shift;
    logic                 w_multi;
    logic [CNT_W-1:0]     w_rem_load;
    logic                 w_hs;

    tl_rr_pick #(
        .N     (N_CLIENTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    // Only IDLE follows the live picker; locked states replay the stored grant.
    assign w_gnt    = (r_state == ST_IDLE) ? w_pick : r_gnt;
    assign gnt_oh_o = w_gnt;

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx = IDX_W'(k);
            end
        end
    end

    assign gnt_idx_o   = w_gnt_idx;
    assign out_valid_o = |(req_valid_i & w_gnt);
    assign req_ready_o = {N_CLIENTS{out_ready_i}} & w_gnt;
    assign w_hs        = out_valid_o & out_ready_i;
    assign busy_o      = (r_state != ST_IDLE);

    // Beat count of the granted message; only meaningful on a first beat.
    assign w_op       = req_opcode_i[int'(w_gnt_idx)*3 +: 3];
    assign w_size     = req_size_i[int'(w_gnt_idx)*4 +: 4];
    assign w_multi    = tl_has_data(w_op) && (w_size > 4'(BEAT_LG));
    assign w_shift    = w_size - 4'(BEAT_LG);
    assign w_rem_load = (CNT_W'(1) << w_shift) - CNT_W'(1);
    assign w_next_ptr = (w_gnt_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

    // A first beat (IDLE or HOLD) advances the pointer and either finishes
    // the message or opens a burst; BURST counts down the remaining beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_hs) begin
                        r_ptr <= w_next_ptr;
                        if (w_multi) begin
                            r_state     <= ST_BURST;
                            r_remaining <= w_rem_load;
                            r_gnt       <= w_gnt;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                        end
                    end else if (r_state == ST_IDLE && out_valid_o) begin
                        r_state <= ST_HOLD;
                        r_gnt   <= w_pick;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        if (r_remaining == CNT_W'(1)) begin
                            r_state     <= ST_IDLE;
                            r_gnt       <= '0;
                            r_remaining <= '0;
                        end else begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tl_a_arbiter
// Self-checking bench for tl_a_arbiter (N_CLIENTS=4, DATA_W=64): a vector
// table, hand-written multi-cycle sequences and a randomized run against an
// owner/beats-left reference model.
// ---------------------------------------------------------------------------
module tb_tl_a_arbiter;

    import tl_a_arbiter_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid_i;
    logic [N-1:0]  req_ready_o;
    logic [N*3-1:0] req_opcode_i;
    logic [N*4-1:0] req_size_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [N-1:0]  gnt_oh_o;
    logic [1:0]    gnt_idx_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] GETS = {TL_OP_GET, TL_OP_GET, TL_OP_GET, TL_OP_GET};
    localparam logic [15:0] SZ3  = {4'd3, 4'd3, 4'd3, 4'd3};

    tl_a_arbiter #(
        .N_CLIENTS (N),
        .DATA_W    (64),
        .CNT_W     (13)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_opcode_i (req_opcode_i),
        .req_size_i   (req_size_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .gnt_oh_o     (gnt_oh_o),
        .gnt_idx_o    (gnt_idx_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] op;
        logic [15:0] sz;
        logic        ready;
        logic [3:0]  expGnt;
        logic        expValid;
        logic        expBusy;
    } vec_t;

    vec_t tbl[10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic [3:0] v, input logic [11:0] op, input logic [15:0] sz, input logic rdy);
        @(negedge clk);
        req_valid_i  = v;
        req_opcode_i = op;
        req_size_i   = sz;
        out_ready_i  = rdy;
        #1;
    endtask

    function automatic int ohIdx(input logic [3:0] oh);
        int r = 0;
        for (int k = 0; k < N; k++) begin
            if (oh[k]) r = k;
        end
        return r;
    endfunction

    task automatic checkAll(input string name, input logic [3:0] expGnt, input logic expValid, input logic expBusy);
        checkOutput({name, " gnt_oh"}, 32'(gnt_oh_o), 32'(expGnt));
        checkOutput({name, " out_valid"}, 32'(out_valid_o), 32'(expValid));
        checkOutput({name, " busy"}, 32'(busy_o), 32'(expBusy));
        checkOutput({name, " req_ready"}, 32'(req_ready_o), 32'(out_ready_i ? expGnt : 4'b0000));
        if (expGnt != 4'b0000) begin
            checkOutput({name, " gnt_idx"}, 32'(gnt_idx_o), 32'(ohIdx(expGnt)));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n        = 1'b0;
        req_valid_i  = '0;
        req_opcode_i = GETS;
        req_size_i   = SZ3;
        out_ready_i  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int beatsOf(input int op, input int sz);
        if (op <= 3 && sz > 3) return 1 << (sz - 3);
        return 1;
    endfunction

    // Reference model: a locked owner (-1 when free), beats still owed by a
    // running burst, and the round-robin start point.
    int ownerM, leftM, ptrM;

    task automatic randomRun(input int cycles);
        logic [3:0] v;
        int         op[N];
        int         sz[N];
        bit         pend[N];
        logic       rdy;
        int         g;
        logic [3:0] expGnt;
        logic       expValid;
        logic       hs;
        ownerM = -1;
        leftM  = 0;
        ptrM   = 0;
        v      = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            op[i]   = 4;
            sz[i]   = 3;
        end
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    v[i]  = ($urandom_range(0, 2) != 0);
                    op[i] = $urandom_range(0, 7);
                    sz[i] = $urandom_range(0, 7);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(v,
                {3'(op[3]), 3'(op[2]), 3'(op[1]), 3'(op[0])},
                {4'(sz[3]), 4'(sz[2]), 4'(sz[1]), 4'(sz[0])}, rdy);
            g = -1;
            if (ownerM >= 0) begin
                g = ownerM;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && v[(ptrM + k) % N]) g = (ptrM + k) % N;
                end
            end
            expGnt   = (g >= 0) ? 4'(1 << g) : 4'b0000;
            expValid = (g >= 0) && v[g];
            checkAll("random", expGnt, expValid, ownerM >= 0);
            hs = expValid && rdy;
            for (int i = 0; i < N; i++) begin
                pend[i] = v[i] && !(hs && g == i);
            end
            if (hs) begin
                if (leftM > 0) begin
                    leftM--;
                    if (leftM == 0) ownerM = -1;
                end else begin
                    ptrM = (g + 1) % N;
                    leftM = beatsOf(op[g], sz[g]) - 1;
                    ownerM = (leftM > 0) ? g : -1;
                end
            end else if (ownerM < 0 && expValid) begin
                ownerM = g;
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid_i  = 4'b0110;
        req_opcode_i = GETS;
        req_size_i   = SZ3;
        out_ready_i  = 1'b1;
        #2;
        checkAll("reset", 4'b0010, 1'b1, 1'b0);
        doReset();

        // Sequential table from reset; each row is one clock.
        tbl[0] = '{4'b0000, GETS, SZ3, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{4'b0010, GETS, SZ3, 1'b1, 4'b0010, 1'b1, 1'b0};
        tbl[2] = '{4'b0011, GETS, SZ3, 1'b1, 4'b0001, 1'b1, 1'b0};
        tbl[3] = '{4'b0100, {TL_OP_GET, TL_OP_PUT_PARTIAL, TL_OP_GET, TL_OP_GET},
                   {4'd3, 4'd2, 4'd3, 4'd3}, 1'b1, 4'b0100, 1'b1, 1'b0};
        tbl[4] = '{4'b0100, GETS, SZ3, 1'b1, 4'b0100, 1'b1, 1'b0};
        tbl[5] = '{4'b0000, GETS, SZ3, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[6] = '{4'b1000, GETS, SZ3, 1'b0, 4'b1000, 1'b1, 1'b0};
        tbl[7] = '{4'b1001, GETS, SZ3, 1'b0, 4'b1000, 1'b1, 1'b1};
        tbl[8] = '{4'b1001, GETS, SZ3, 1'b1, 4'b1000, 1'b1, 1'b1};
        tbl[9] = '{4'b0001, GETS, SZ3, 1'b1, 4'b0001, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].op, tbl[i].sz, tbl[i].ready);
            checkAll($sformatf("table[%0d]", i), tbl[i].expGnt, tbl[i].expValid, tbl[i].expBusy);
        end

        // 4-beat PutFullData from client 0, client 2 waiting behind it.
        doReset();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'b0101, {TL_OP_GET, TL_OP_GET, TL_OP_GET, TL_OP_PUT_FULL},
                          {4'd3, 4'd3, 4'd3, 4'd5}, 1'b1);
            checkAll($sformatf("burst beat%0d", b), 4'b0001, 1'b1, b != 0);
        end
        applyStimulus(4'b0101, GETS, SZ3, 1'b1);
        checkAll("after burst", 4'b0100, 1'b1, 1'b0);

        // Client 3 stalled by backpressure while client 0 raises valid.
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c == 0) ? 4'b1000 : 4'b1001, GETS, SZ3, 1'b0);
            checkAll($sformatf("hold c%0d", c), 4'b1000, 1'b1, c != 0);
        end
        applyStimulus(4'b1001, GETS, SZ3, 1'b1);
        checkAll("hold release", 4'b1000, 1'b1, 1'b1);
        applyStimulus(4'b0001, GETS, SZ3, 1'b1);
        checkAll("after hold", 4'b0001, 1'b1, 1'b0);

        // All clients continuously issuing Gets rotate one grant per cycle.
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b1111, GETS, SZ3, 1'b1);
            checkAll($sformatf("rotate c%0d", c), 4'(1 << (c % N)), 1'b1, 1'b0);
        end

        // Reset in the middle of an 8-beat burst.
        doReset();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(4'b0011, {TL_OP_GET, TL_OP_GET, TL_OP_GET, TL_OP_PUT_FULL},
                          {4'd3, 4'd3, 4'd3, 4'd6}, 1'b1);
            checkAll($sformatf("rst burst beat%0d", b), 4'b0001, 1'b1, b != 0);
        end
        @(negedge clk);
        req_valid_i = 4'b0010;
        rst_n       = 1'b0;
        #1;
        checkAll("mid-burst reset", 4'b0010, 1'b1, 1'b0);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0011, GETS, SZ3, 1'b1);
        checkAll("after mid-burst reset", 4'b0001, 1'b1, 1'b0);

        doReset();
        randomRun(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
